// File: rtl/traffic_phase_scheduler_if.sv
// Bundle between the sensor front end / lamp drivers and traffic_phase_scheduler.
// The master drives the tick strobe, vehicle sensors and emergency requests and
// observes the lamps. The slave is the scheduler itself.
interface traffic_phase_scheduler_if;
   logic       tick;
   logic [8:1] sensors;
   logic [4:1] emerg_req;
   logic [4:1] green;
   logic [4:1] yellow;
   logic       all_red;
   logic       phase_start;

   modport master (
      output tick, sensors, emerg_req,
      input  green, yellow, all_red, phase_start
   );

   modport slave (
      input  tick, sensors, emerg_req,
      output green, yellow, all_red, phase_start
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: GREEN -> YELLOW -> ALL_RED -> GREEN.
// Green is handed round-robin to approaches with vehicle demand. The green
// dwell is long when both sensors of the granted approach are active.
// All intervals count tick strobes, not clock cycles.
// Optional build macro EMERGENCY_PREEMPT_EN enables emergency-vehicle
// preemption. Without it, emerg_req is ignored.
module traffic_phase_scheduler #(
   parameter int GREEN_SHORT = 30,
   parameter int GREEN_LONG  = 60,
   parameter int YELLOW_T    = 4,
   parameter int ALL_RED_T   = 2,
   parameter int CW          = 7
) (
   input logic                     clk,
   input logic                     rst,
   traffic_phase_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      GREEN   = 2'd0,
      YELLOW  = 2'd1,
      ALL_RED = 2'd2
   } state_t;

   localparam logic [CW-1:0] T_ONE     = CW'(1);
   localparam logic [CW-1:0] T_SHORT   = CW'(GREEN_SHORT);
   localparam logic [CW-1:0] T_LONG    = CW'(GREEN_LONG);
   localparam logic [CW-1:0] T_YELLOW  = CW'(YELLOW_T);
   localparam logic [CW-1:0] T_ALL_RED = CW'(ALL_RED_T);

   // Saturating down-count: the timer stops at 1 and never wraps.
   function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] t);
      return (t > T_ONE) ? t - T_ONE : T_ONE;
   endfunction

   // Approach index (0..3 for approaches 1..4) to one-hot lamp vector.
   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] timer_q, timer_d;
   logic          ps_d;

   logic [3:0]    green_q, yellow_q;
   logic          all_red_q, phase_start_q;

   logic [7:0]    sens;
   logic [3:0]    dem, heavy;
   logic          other_dem;
   logic          expire;

   logic          emerg_act;
   logic [1:0]    emerg_idx;
   logic          emerg_serving;

   logic [1:0]    nxt;
   logic [1:0]    cand;
   logic          found;

   // Approach k (index k-1) owns sensor bits 2k-1 and 2k.
   assign sens  = bus.sensors;
   assign dem   = {sens[7] | sens[6], sens[5] | sens[4], sens[3] | sens[2], sens[1] | sens[0]};
   assign heavy = {sens[7] & sens[6], sens[5] & sens[4], sens[3] & sens[2], sens[1] & sens[0]};

   assign other_dem = |(dem & ~onehot(ptr_q));
   assign expire    = bus.tick && (timer_q <= T_ONE);

`ifdef EMERGENCY_PREEMPT_EN
   logic [3:0] emerg;
   assign emerg = bus.emerg_req;

   // Lowest-indexed request is the active emergency. The green approach keeps
   // its grant while its own request stays high, even if a lower one appears.
   always_comb begin
      emerg_act = |emerg;
      emerg_idx = 2'd0;
      if (emerg[0])      emerg_idx = 2'd0;
      else if (emerg[1]) emerg_idx = 2'd1;
      else if (emerg[2]) emerg_idx = 2'd2;
      else if (emerg[3]) emerg_idx = 2'd3;
      emerg_serving = emerg[ptr_q];
   end
`else
   logic unused_emerg;
   assign unused_emerg  = ^bus.emerg_req;
   assign emerg_act     = 1'b0;
   assign emerg_idx     = 2'd0;
   assign emerg_serving = 1'b0;
`endif

   // Next green owner: emergency first, else first demand after ptr, else ptr+1.
   always_comb begin
      nxt   = ptr_q + 2'd1;
      cand  = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && dem[cand]) begin
            nxt   = cand;
            found = 1'b1;
         end
      end
      if (emerg_act) nxt = emerg_idx;
   end

   // Next-state logic for the phase FSM, grant pointer and interval timer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      ps_d    = 1'b0;
      case (state_q)
         GREEN: begin
            if (emerg_serving) begin
               if (bus.tick) timer_d = dec_sat(timer_q);
            end else if (emerg_act) begin
               state_d = YELLOW;
               timer_d = T_YELLOW;
            end else if (expire) begin
               if (other_dem) begin
                  state_d = YELLOW;
                  timer_d = T_YELLOW;
               end
            end else if (bus.tick) begin
               timer_d = dec_sat(timer_q);
            end
         end
         YELLOW: begin
            if (expire) begin
               state_d = ALL_RED;
               timer_d = T_ALL_RED;
            end else if (bus.tick) begin
               timer_d = dec_sat(timer_q);
            end
         end
         ALL_RED: begin
            if (expire) begin
               state_d = GREEN;
               ptr_d   = nxt;
               timer_d = heavy[nxt] ? T_LONG : T_SHORT;
               ps_d    = 1'b1;
            end else if (bus.tick) begin
               timer_d = dec_sat(timer_q);
            end
         end
         default: begin
            state_d = ALL_RED;
            timer_d = T_ALL_RED;
         end
      endcase
   end

   // State, pointer, timer and registered lamp outputs, all on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ALL_RED;
         ptr_q         <= 2'd3;
         timer_q       <= T_ALL_RED;
         green_q       <= 4'b0000;
         yellow_q      <= 4'b0000;
         all_red_q     <= 1'b1;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         timer_q       <= timer_d;
         green_q       <= (state_d == GREEN)  ? onehot(ptr_d) : 4'b0000;
         yellow_q      <= (state_d == YELLOW) ? onehot(ptr_d) : 4'b0000;
         all_red_q     <= (state_d == ALL_RED);
         phase_start_q <= ps_d;
      end
   end

   assign bus.green       = green_q;
   assign bus.yellow      = yellow_q;
   assign bus.all_red     = all_red_q;
   assign bus.phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler.
// The stimulus process queues the hand-derived lamp vector expected after each
// clock edge. The monitor process pops and compares one entry per edge.
// An asynchronous-reset check uses an event instead of an edge.
module tb_traffic_phase_scheduler;

   logic clk = 1'b0;
   logic rst;

   traffic_phase_scheduler_if bus();

   traffic_phase_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] v;    // {green, yellow, all_red, phase_start}
      string      name;
      int         idx;
   } item_t;

   item_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    step_no = 0;
   event  async_ev;

   // Monitor: compare one queued expectation after each edge or async request.
   initial begin : monitor
      item_t      it;
      logic [9:0] act;
      forever begin
         @(posedge clk or async_ev);
         #1;
         if (exp_q.size() != 0) begin
            it  = exp_q.pop_front();
            act = {bus.green, bus.yellow, bus.all_red, bus.phase_start};
            checks++;
            if (act !== it.v) begin
               errors++;
               $display("FAIL %s step %0d: got green=%b yellow=%b all_red=%b phase_start=%b, want green=%b yellow=%b all_red=%b phase_start=%b",
                        it.name, it.idx, act[9:6], act[5:2], act[1], act[0],
                        it.v[9:6], it.v[5:2], it.v[1], it.v[0]);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input logic [3:0] g, input logic [3:0] y, input logic ar,
                       input logic ps, input string nm);
      item_t it;
      it.v    = {g, y, ar, ps};
      it.name = nm;
      it.idx  = step_no;
      step_no++;
      exp_q.push_back(it);
      @(negedge clk);
   endtask

   task automatic run(input logic [3:0] g, input logic [3:0] y, input logic ar,
                      input int n, input string nm);
      for (int i = 0; i < n; i++) step(g, y, ar, 1'b0, nm);
   endtask

   // A green interval of n cycles starting with the phase_start pulse.
   task automatic phase(input logic [3:0] g, input int n, input string nm);
      step(g, 4'b0000, 1'b0, 1'b1, nm);
      run(g, 4'b0000, 1'b0, n - 1, nm);
   endtask

   // Yellow on the previous approach for 4 cycles, then 2 all-red cycles.
   task automatic clear(input logic [3:0] g, input string nm);
      run(4'b0000, g, 1'b0, 4, nm);
      run(4'b0000, 4'b0000, 1'b1, 2, nm);
   endtask

   // Check reset values immediately, without waiting for a clock edge.
   task automatic async_chk(input string nm);
      item_t it;
      it.v    = {4'b0000, 4'b0000, 1'b1, 1'b0};
      it.name = nm;
      it.idx  = step_no;
      step_no++;
      exp_q.push_back(it);
      ->async_ev;
      @(negedge clk);
   endtask

   // Stimulus: directed scenarios with hand-computed lamp sequences.
   initial begin : stimulus
      rst           = 1'b1;
      bus.tick      = 1'b1;
      bus.sensors   = 8'h00;
      bus.emerg_req = 4'b0000;
      @(negedge clk);
      async_chk("reset_values");

      // Rest in green with no demand.
      rst = 1'b0;
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "s1_all_red");
      phase(4'b0001, 40, "s1_rest_green");

      // Light vs heavy dwell.
      bus.sensors = 8'b0000_0100;
      clear(4'b0001, "s2_clear_a1");
      phase(4'b0010, 30, "s2_light_a2");
      bus.sensors = 8'b0000_0001;
      clear(4'b0010, "s2_clear_a2");
      phase(4'b0001, 30, "s2_light_a1");
      bus.sensors = 8'b0000_1100;
      clear(4'b0001, "s2_clear_a1b");
      phase(4'b0010, 60, "s2_heavy_a2");

      // Round-robin with every sensor active.
      bus.sensors = 8'hFF;
      clear(4'b0010, "s3_clear_a2");
      phase(4'b0100, 60, "s3_green_a3");
      clear(4'b0100, "s3_clear_a3");
      phase(4'b1000, 60, "s3_green_a4");
      clear(4'b1000, "s3_clear_a4");
      phase(4'b0001, 60, "s3_green_a1");
      clear(4'b0001, "s3_clear_a1");
      phase(4'b0010, 60, "s3_green_a2");

      // Emergency request on approach 4 during green on approach 1.
      rst           = 1'b1;
      bus.sensors   = 8'h00;
      bus.emerg_req = 4'b0000;
      async_chk("s4_reset_in_green");
      rst = 1'b0;
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "s4_all_red");
      phase(4'b0001, 10, "s4_green_a1");
      bus.emerg_req = 4'b1000;
      bus.sensors   = 8'h41;
`ifdef EMERGENCY_PREEMPT_EN
      clear(4'b0001, "s4_abort_a1");
      step(4'b1000, 4'b0000, 1'b0, 1'b1, "s4_emerg_a4");
      run(4'b1000, 4'b0000, 1'b0, 34, "s4_hold_a4");
      bus.emerg_req = 4'b1001;
      run(4'b1000, 4'b0000, 1'b0, 35, "s4_hold_a4_second_req");
      bus.emerg_req = 4'b0001;
      clear(4'b1000, "s4_abort_a4");
      phase(4'b0001, 30, "s4_emerg_a1");
      bus.emerg_req = 4'b0000;
`else
      run(4'b0001, 4'b0000, 1'b0, 20, "s5_full_dwell_a1");
      clear(4'b0001, "s5_clear_a1");
      phase(4'b1000, 30, "s5_demand_a4");
      clear(4'b1000, "s5_clear_a4");
      phase(4'b0001, 30, "s5_demand_a1");
      bus.emerg_req = 4'b0000;
`endif

      // Tick gating and asynchronous reset mid-yellow.
      rst         = 1'b1;
      bus.sensors = 8'h00;
      async_chk("s6_reset");
      rst = 1'b0;
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "s6_all_red");
      phase(4'b0001, 30, "s6_rest_a1");
      bus.sensors = 8'b0000_0100;
      for (int i = 0; i < 12; i++) begin
         bus.tick = (i % 3 == 0);
         step(4'b0000, 4'b0001, 1'b0, 1'b0, "s6_gated_yellow");
      end
      for (int i = 12; i < 19; i++) begin
         bus.tick = (i % 3 == 0);
         if (i < 18) step(4'b0000, 4'b0000, 1'b1, 1'b0, "s6_gated_all_red");
         else        step(4'b0010, 4'b0000, 1'b0, 1'b1, "s6_gated_green");
      end
      bus.tick = 1'b0;
      step(4'b0010, 4'b0000, 1'b0, 1'b0, "s6_single_pulse");
      bus.tick    = 1'b1;
      bus.sensors = 8'h01;
      run(4'b0010, 4'b0000, 1'b0, 29, "s6_green_a2");
      run(4'b0000, 4'b0010, 1'b0, 2, "s6_yellow_a2");
      rst = 1'b1;
      async_chk("s6_reset_mid_yellow");
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "s6_reset_held");
      rst = 1'b0;
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "s6_restart_all_red");
      phase(4'b0001, 5, "s6_restart_green_a1");

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

- Sequences the four-approach intersection through green, yellow and all-red intervals.
- Shares the green phase between the four approaches:
  - round-robin order driven by vehicle sensors;
  - green dwell time chosen by demand level;
  - optional emergency-vehicle preemption.
- Sits between the sensor front end and the lamp drivers. All timing is counted in `tick` periods, not clock cycles.

## Interface

- `GREEN_SHORT`, 30: green dwell in ticks when one of the granted approach's two sensors is active, or none is.
- `GREEN_LONG`, 60: green dwell in ticks when both sensors of the granted approach are active.
- `YELLOW_T`, 4: yellow interval in ticks.
- `ALL_RED_T`, 2: all-red clearance in ticks.
- `CW`, 7: interval timer width. Every interval parameter must be ≥1 and <2^CW.

Ports:

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `tick`  in  1  one-cycle timebase strobe; the timer advances only when it is high
- `sensors`  in  8 [8:1]  approach k uses bits 2k-1 and 2k
- `emerg_req`  in  4 [4:1]  emergency preemption request per approach
- `green`  out  4 [4:1]  one-hot green lamp, or 0
- `yellow`  out  4 [4:1]  one-hot yellow lamp, or 0
- `all_red`  out  1  high in the ALL_RED state
- `phase_start`  out  1  one-cycle pulse on the edge that enters GREEN

## Operation

- Per-approach signals:
  - `dem[k] = sensors[2k-1] | sensors[2k]`
  - `heavy[k] = sensors[2k-1] & sensors[2k]`
- State registers:
  - FSM state: GREEN, YELLOW or ALL_RED.
  - 2-bit grant pointer `ptr`, holding the approach that owns or last owned green.
  - Down-counter `timer`.
- A state is left on a tick cycle with `timer==1`, so each state lasts exactly N ticks. Emergency abort is the only exception.

GREEN:
- Lamp `green[ptr+1]` is on.
- When `timer==1` on a tick, either condition causes a move to YELLOW with `timer=YELLOW_T`:
  - any other approach has `dem`;
  - an active emergency targets another approach.
- Otherwise the block rests in green: `timer` holds at 1 and the exit is re-evaluated every tick.

YELLOW:
- Lamp `yellow[ptr+1]` is on.
- On expiry, move to ALL_RED with `timer=ALL_RED_T`.

ALL_RED:
- All lamps are off and `all_red=1`.
- On expiry, select the next approach `nxt`, load `timer`, set `ptr=nxt`, enter GREEN and pulse `phase_start`. Selection order:
  1. Active emergency: its approach.
  2. Otherwise, the first approach with `dem`, searching `ptr+1, ptr+2, ptr+3, ptr` (mod 4).
  3. Otherwise, `ptr+1`.
- Timer load: `GREEN_LONG` if `heavy[nxt]`, else `GREEN_SHORT`.

Emergency:
- Active emergency means the lowest-indexed asserted `emerg_req` bit.
- In GREEN with the emergency on another approach: go to YELLOW on the next clk edge regardless of `tick` or `timer`.
- In GREEN on the emergency approach: green is held while the request stays asserted. The timer is not allowed to expire it; it holds at 1.
- An emergency raised in YELLOW or ALL_RED does not shorten those intervals. It only wins selection at ALL_RED exit.
- A second emergency raised while the first is being served takes effect only after the first is released.

Other rules:
- `sensors` and `emerg_req` are sampled directly at the decision edge. There is no latching.
- `timer` never underflows and never wraps.

## Timing

- Reset values:
  - state ALL_RED, `timer=ALL_RED_T`, `ptr=3`;
  - `green=0`, `yellow=0`, `all_red=1`, `phase_start=0`.
- All outputs are registered and change on the same edge as the state.
- Latency:
  - normal transitions: the edge of the tick cycle on which `timer==1`;
  - emergency abort: one clk edge after `emerg_req` is seen in GREEN.
- `tick` low freezes `timer` and all tick-driven transitions. `tick` held high means one tick per cycle.
- Reset mid-interval (for example during YELLOW): outputs go to their reset values immediately. The sequence restarts with ALL_RED for 2 ticks.
- With no demand from reset: ALL_RED for 2 ticks, then GREEN on approach 1 for `GREEN_SHORT`, then rest in green.

## Configuration

- `EMERGENCY_PREEMPT_EN` defined: emergency behaviour is exactly as described under Operation.
- Not defined:
  - `emerg_req` is ignored; the port remains;
  - selection is demand round-robin only;
  - no GREEN is aborted or held by emergency.

## Test plan

All scenarios use default parameters and `tick` tied high.

1. Rest in green: reset with `sensors=0`.
   - `all_red=1` for 2 cycles, then `green=4'b0001` with a `phase_start` pulse.
   - Green holds indefinitely; `yellow` stays 0.
2. Light vs heavy dwell: from resting green on approach 1, set `sensors=8'b0000_0100`.
   - Expected sequence: `yellow=0001` for 4 cycles, `all_red` for 2 cycles, `green=0010` for 30 cycles.
   - Repeat with `sensors=8'b0000_1100`: green on approach 2 lasts 60 cycles.
3. Round-robin fairness: set `sensors=8'hFF`.
   - Green order is 1, 2, 3, 4, 1, each for 60 cycles.
   - Each green is separated by 4 yellow and 2 all-red cycles.
4. Emergency abort and hold (macro defined): during green on approach 1, assert `emerg_req=4'b1000` at cycle 10.
   - `yellow=0001` on the next edge, then all-red, then `green=1000`.
   - Green on approach 4 holds past 60 cycles while the request stays asserted.
   - Normal round-robin resumes after release.
5. Macro undefined: repeat scenario 4.
   - Green on approach 1 runs its full dwell; `emerg_req` has no effect.
6. Tick gating and reset: with tick pulsed every 3rd cycle, the yellow interval spans 12 cycles.
   - Asserting `rst` mid-yellow forces `yellow=0` and `all_red=1` asynchronously.
